// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: shared state type, request record and sizing helpers for the data memory responder.
// Latency: none; types, constants and a constant function only.
// Backpressure: none.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OFS_W      = $clog2(WORD_BYTES);  // byte-offset bits inside a word

  // Request as captured in the IDLE acceptance cycle; err is decided once, up front.
  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdat;
  } dmem_req_t;

  // log2 of a power-of-two depth: number of word-index bits.
  function automatic int unsigned idx_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = unsigned'(i + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store port between the CPU (master) and the responder (slave).
// Latency: wires only.
// Backpressure: ready_o/stall_o from the slave hold the pipeline until resp_o.
//
// Master drives req_i, we_i, addr_i (byte address), wdata_i.
// Slave drives ready_o, stall_o, resp_o (1-cycle pulse), rdata_o, err_o.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        stall_o;
  logic        resp_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, stall_o, resp_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, stall_o, resp_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port word RAM, synchronous write, 1-cycle registered read.
// Latency: read data valid the cycle after re_i; write lands on the edge with we_i.
// Backpressure: none; the caller never issues read and write in the same cycle.
//
// Ports: clk_i, rst_n_i (clears the read register only), idx_i word index,
// we_i/wdat_i write, re_i read strobe, rdat_o registered read data (0 when not read).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [idx_w(DEPTH_WORDS)-1:0] idx_i,
  input  logic                          we_i,
  input  logic [DATA_W-1:0]             wdat_i,
  input  logic                          re_i,
  output logic [DATA_W-1:0]             rdat_o
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdat_q;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdat_i;
  end

  // The read register returns to 0 whenever no read is issued, so the
  // output is 0 on every cycle that is not a good-load response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdat_q <= '0;
    end else if (re_i) begin
      rdat_q <= mem[idx_i];
    end else begin
      rdat_q <= '0;
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with a fixed, configurable access latency.
// Latency: accept in IDLE, resp_o pulses LATENCY cycles later (stall_o high for LATENCY cycles).
// Backpressure: one request in flight; ready_o low and inputs ignored until back in IDLE.
//
// Ports: clk_i, rst_n_i (async, active low), bus (slave modport of dmem_responder_if):
// req_i/we_i/addr_i/wdata_i in; ready_o, stall_o, resp_o, rdata_o, err_o out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,  // power of two, >= 4
  parameter int unsigned LATENCY     = 3     // 1..15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IW       = idx_w(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  dmem_req_t     req_q;

  logic          accept;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic          cur_err;

  logic [IW-1:0] ram_idx;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdat;

  assign accept = (state_q == IDLE) && bus.req_i;

  // In IDLE the live inputs describe the request (needed when LATENCY=1,
  // where the array read happens in the acceptance cycle itself); after
  // that only the latched copy is used, so input changes have no effect.
  assign cur_we   = (state_q == IDLE) ? bus.we_i   : req_q.we;
  assign cur_addr = (state_q == IDLE) ? bus.addr_i : req_q.addr;

  // Misaligned, or any bit above the word index set.
  assign cur_err = (cur_addr[OFS_W-1:0] != '0) ||
                   ((cur_addr >> (IW + OFS_W)) != 32'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q.we   <= bus.we_i;
        req_q.err  <= cur_err;
        req_q.addr <= bus.addr_i;
        req_q.wdat <= bus.wdata_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus.ready_o = 1'b0;
    bus.stall_o = 1'b0;
    bus.resp_o  = 1'b0;
    bus.err_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        bus.stall_o = bus.req_i;
        if (bus.req_i) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        bus.stall_o = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        bus.resp_o = 1'b1;
        bus.err_o  = req_q.err;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read is launched on the edge that enters RESP so the registered array
  // output lines up with resp_o; writes commit on the edge leaving RESP.
  assign ram_re  = (state_d == RESP) && !cur_we && !cur_err;
  assign ram_we  = (state_q == RESP) && req_q.we && !req_q.err;
  assign ram_idx = cur_addr[IW+OFS_W-1:OFS_W];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (32)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .idx_i   (ram_idx),
    .we_i    (ram_we),
    .wdat_i  (req_q.wdat),
    .re_i    (ram_re),
    .rdat_o  (ram_rdat)
  );

  assign bus.rdata_o = ram_rdat;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives identical stimulus into a LATENCY=3 and a LATENCY=1 responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  dmem_responder_if bus_l3 ();
  dmem_responder_if bus_l1 ();

  assign bus_l3.req_i   = req;
  assign bus_l3.we_i    = we;
  assign bus_l3.addr_i  = addr;
  assign bus_l3.wdata_i = wdata;
  assign bus_l1.req_i   = req;
  assign bus_l1.we_i    = we;
  assign bus_l1.addr_i  = addr;
  assign bus_l1.wdata_i = wdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut_l3 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_l3.slave)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_l1.slave)
  );

  logic        ready_w [2];
  logic        stall_w [2];
  logic        resp_w  [2];
  logic        err_w   [2];
  logic [31:0] rdata_w [2];

  assign ready_w[0] = bus_l3.ready_o;
  assign stall_w[0] = bus_l3.stall_o;
  assign resp_w[0]  = bus_l3.resp_o;
  assign err_w[0]   = bus_l3.err_o;
  assign rdata_w[0] = bus_l3.rdata_o;
  assign ready_w[1] = bus_l1.ready_o;
  assign stall_w[1] = bus_l1.stall_o;
  assign resp_w[1]  = bus_l1.resp_o;
  assign err_w[1]   = bus_l1.err_o;
  assign rdata_w[1] = bus_l1.rdata_o;

  // Transaction-level reference: a request seen in cycle ta completes in
  // cycle ta+L; writes land in the word store at the end of that cycle.
  int          lat_m   [2] = '{3, 1};
  bit          busy_m  [2];
  int          ta_m    [2];
  bit          pwe_m   [2];
  logic [31:0] paddr_m [2];
  logic [31:0] pwd_m   [2];
  logic [31:0] mem_m   [2][DEPTH];

  int cyc;
  int n_vec;
  int n_err;
  bit count_en;
  int resp_cnt [2];

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut_l%0d cycle %0d: observed %h expected %h", tag, lat_m[k], cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      logic        e_ready, e_stall, e_resp, e_err;
      logic [31:0] e_rdata;
      int          el;
      e_ready = 1'b1;
      e_stall = req;
      e_resp  = 1'b0;
      e_err   = 1'b0;
      e_rdata = 32'd0;
      if (busy_m[k]) begin
        el      = cyc - ta_m[k];
        e_ready = 1'b0;
        if (el >= lat_m[k]) begin
          e_resp  = 1'b1;
          e_stall = 1'b0;
          e_err   = addr_bad(paddr_m[k]);
          if (!e_err && !pwe_m[k]) e_rdata = mem_m[k][word_of(paddr_m[k])];
        end else begin
          e_stall = 1'b1;
        end
      end
      chk("ready", k, 32'(ready_w[k]), 32'(e_ready));
      chk("stall", k, 32'(stall_w[k]), 32'(e_stall));
      chk("resp",  k, 32'(resp_w[k]),  32'(e_resp));
      chk("err",   k, 32'(err_w[k]),   32'(e_err));
      chk("rdata", k, rdata_w[k], e_rdata);
      if (count_en && resp_w[k] === 1'b1) resp_cnt[k]++;
    end
  endtask

  task automatic edge_update();
    for (int k = 0; k < 2; k++) begin
      if (busy_m[k] && (cyc - ta_m[k]) >= lat_m[k]) begin
        if (pwe_m[k] && !addr_bad(paddr_m[k])) mem_m[k][word_of(paddr_m[k])] = pwd_m[k];
        busy_m[k] = 1'b0;
      end else if (!busy_m[k] && req && rst_n) begin
        busy_m[k]  = 1'b1;
        ta_m[k]    = cyc;
        pwe_m[k]   = we;
        paddr_m[k] = addr;
        pwd_m[k]   = wdata;
      end
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    edge_update();
    #1;
  endtask

  // One request cycle, then enough idle cycles (with junk on the data
  // inputs) for the slower responder to finish.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, w, a, d);
    repeat (4) step(1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic check_reset_outs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", k, 32'(stall_w[k]), 32'd0);
      chk("rst_resp",  k, 32'(resp_w[k]),  32'd0);
      chk("rst_err",   k, 32'(err_w[k]),   32'd0);
      chk("rst_rdata", k, rdata_w[k],      32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          cls;

    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    count_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      busy_m[k]   = 1'b0;
      resp_cnt[k] = 0;
      for (int i = 0; i < int'(DEPTH); i++) mem_m[k][i] = 32'd0;
    end

    // Reset state.
    #1;
    check_reset_outs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    edge_update();
    #1;

    // Give words 0..15 known contents.
    for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom);

    // Store then load through the same word.
    txn(1'b1, 32'h10, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0);

    // Back-to-back loads with req held high.
    txn(1'b1, 32'h0, 32'd1);
    txn(1'b1, 32'h4, 32'd2);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h4, 32'h0);
    step(1'b1, 1'b0, 32'h4, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Error responses: misaligned load, out-of-range store, then word 0 untouched.
    txn(1'b0, 32'h13, 32'h0);
    txn(1'b1, 32'h400, 32'hBAD0BAD0);
    txn(1'b0, 32'h0, 32'h0);

    // Inputs wiggled while the request is in flight.
    step(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    step(1'b0, 1'b1, 32'h24, 32'h11111111);
    step(1'b0, 1'b1, 32'h24, 32'h22222222);
    step(1'b0, 1'b1, 32'h28, 32'h33333333);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 32'h20, 32'h0);
    txn(1'b0, 32'h24, 32'h0);
    txn(1'b0, 32'h28, 32'h0);

    // Reset during the in-flight store of 0x55 to 0x8.
    step(1'b1, 1'b1, 32'h8, 32'h55);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check_reset_outs();
    for (int k = 0; k < 2; k++) busy_m[k] = 1'b0;
    @(posedge clk);
    edge_update();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    edge_update();
    #1;
    txn(1'b0, 32'h8, 32'h0);

    // req held for 12 cycles: 12/(L+1) responses each.
    count_en = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'(4 * $urandom_range(0, 15)), 32'h0);
    count_en = 1'b0;
    repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) chk("resp_count", k, 32'(resp_cnt[k]), 32'(12 / (lat_m[k] + 1)));

    // Random traffic over the initialised words with occasional bad addresses.
    for (int i = 0; i < 400; i++) begin
      cls = int'($urandom_range(0, 9));
      a   = 32'(4 * $urandom_range(0, 15));
      if (cls == 0)      a = a + 32'($urandom_range(1, 3));
      else if (cls == 1) a = a | (32'd1 << $urandom_range(10, 31));
      step(1'($urandom_range(0, 2) != 0), 1'($urandom), a, $urandom);
    end
    repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
